// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule definitions: word/round sizes, FSM states
// and the small-sigma functions used by the expansion datapath.
package sha256_pkg;

  localparam int SHA_WORD_W      = 32;
  localparam int SHA_ROUNDS      = 64;
  localparam int SHA_BLOCK_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    FLUSH  = 2'd3
  } sched_state_e;

  // Rotates are written as bit-select concatenations so they are pure wiring.
  function automatic logic [SHA_WORD_W-1:0] sigma0(input logic [SHA_WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [SHA_WORD_W-1:0] sigma1(input logic [SHA_WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/reduce4to2_nbit.sv
// 4:2 carry-save compressor built from two 3:2 levels. o_sum + o_carry equals
// i_a + i_b + i_c + i_d modulo 2^WIDTH; carries out of the top bit are dropped.
module reduce4to2_nbit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_carry
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] c1;
  logic [WIDTH-2:0] maj1;
  logic [WIDTH-2:0] maj2;

  // Majority of the top bit would shift out of the word, so it is never formed.
  assign s1   = i_a ^ i_b ^ i_c;
  assign maj1 = (i_a[WIDTH-2:0] & i_b[WIDTH-2:0]) |
                (i_a[WIDTH-2:0] & i_c[WIDTH-2:0]) |
                (i_b[WIDTH-2:0] & i_c[WIDTH-2:0]);
  assign c1   = {maj1, 1'b0};

  assign o_sum = s1 ^ c1 ^ i_d;
  assign maj2  = (s1[WIDTH-2:0] & c1[WIDTH-2:0]) |
                 (s1[WIDTH-2:0] & i_d[WIDTH-2:0]) |
                 (c1[WIDTH-2:0] & i_d[WIDTH-2:0]);
  assign o_carry = {maj2, 1'b0};

endmodule

// File: rtl/sha256_sched_word.sv
// Combinational SHA-256 schedule word: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
// The four addends are compressed to two vectors before one carry-propagate add.
module sha256_sched_word
  import sha256_pkg::*;
#(
  parameter int WIDTH = SHA_WORD_W
) (
  input  logic [WIDTH-1:0] i_w2,
  input  logic [WIDTH-1:0] i_w7,
  input  logic [WIDTH-1:0] i_w15,
  input  logic [WIDTH-1:0] i_w16,
  output logic [WIDTH-1:0] o_w_new
);

  logic [WIDTH-1:0] s1_w2;
  logic [WIDTH-1:0] s0_w15;
  logic [WIDTH-1:0] csa_sum;
  logic [WIDTH-1:0] csa_carry;

  assign s1_w2  = sigma1(i_w2);
  assign s0_w15 = sigma0(i_w15);

  reduce4to2_nbit #(WIDTH) u_csa (
    .i_a    (s1_w2),
    .i_b    (i_w7),
    .i_c    (s0_w15),
    .i_d    (i_w16),
    .o_sum  (csa_sum),
    .o_carry(csa_carry)
  );

  assign o_w_new = csa_sum + csa_carry;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message scheduler: forwards W[0..15] from the padder, then expands
// W[16..NUM_ROUNDS-1] from a 16-word sliding window, one word per free output slot.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int WIDTH      = SHA_WORD_W,  // only 32 is meaningful for the sigma rotates
  parameter int NUM_ROUNDS = SHA_ROUNDS   // must exceed 16 and fit the 6-bit index
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_word_valid,
  output logic             o_word_ready,
  output logic [WIDTH-1:0] o_w,
  output logic [5:0]       o_t,
  output logic             o_w_valid,
  input  logic             i_w_ready,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [5:0] T_LAST_LOAD = 6'(SHA_BLOCK_WORDS - 1);
  localparam logic [5:0] T_LAST      = 6'(NUM_ROUNDS - 1);

  sched_state_e     state_q, state_d;
  logic [5:0]       t_q, t_d;
  logic [WIDTH-1:0] win_q [SHA_BLOCK_WORDS];
  logic [WIDTH-1:0] win_d [SHA_BLOCK_WORDS];
  logic [WIDTH-1:0] w_q, w_d;
  logic [5:0]       ot_q, ot_d;
  logic             wv_q, wv_d;
  logic             done_q, done_d;

  logic             slot_free;
  logic             accept;
  logic             issue;
  logic [WIDTH-1:0] issue_word;
  logic [WIDTH-1:0] w_new;

  // The output register can take a new word when empty or being drained this cycle.
  assign slot_free  = !wv_q || i_w_ready;
  assign accept     = (state_q == LOAD) && slot_free && i_word_valid;
  assign issue      = accept || ((state_q == EXPAND) && slot_free);
  assign issue_word = (state_q == LOAD) ? i_word : w_new;

  sha256_sched_word #(.WIDTH(WIDTH)) u_word (
    .i_w2   (win_q[14]),
    .i_w7   (win_q[9]),
    .i_w15  (win_q[1]),
    .i_w16  (win_q[0]),
    .o_w_new(w_new)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_start) state_d = LOAD;
      LOAD:    if (accept && (t_q == T_LAST_LOAD)) state_d = EXPAND;
      EXPAND:  if (slot_free && (t_q == T_LAST)) state_d = FLUSH;
      FLUSH:   if (i_w_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    t_d    = t_q;
    w_d    = w_q;
    ot_d   = ot_q;
    wv_d   = wv_q;
    win_d  = win_q;
    done_d = (state_q == FLUSH) && i_w_ready;

    if ((state_q == IDLE) && i_start) begin
      t_d = '0;
    end

    if (issue) begin
      w_d  = issue_word;
      ot_d = t_q;
      wv_d = 1'b1;
      t_d  = t_q + 6'd1;
      for (int k = 0; k < SHA_BLOCK_WORDS - 1; k++) begin
        win_d[k] = win_q[k+1];
      end
      win_d[SHA_BLOCK_WORDS-1] = issue_word;
    end else if (slot_free) begin
      // Slot drained (or already empty) with nothing new to place in it.
      wv_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      t_q    <= '0;
      w_q    <= '0;
      ot_q   <= '0;
      wv_q   <= 1'b0;
      done_q <= 1'b0;
      for (int k = 0; k < SHA_BLOCK_WORDS; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      t_q    <= t_d;
      w_q    <= w_d;
      ot_q   <= ot_d;
      wv_q   <= wv_d;
      done_q <= done_d;
      win_q  <= win_d;
    end
  end

  always_comb begin
    o_word_ready = (state_q == LOAD) && slot_free;
    o_busy       = (state_q != IDLE);
    o_w          = w_q;
    o_t          = ot_q;
    o_w_valid    = wv_q;
    o_done       = done_q;
  end

endmodule
